// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filters the PS/2 clock, deserialises 11-bit frames
// and folds E0/F0 prefixes into flags so one key event gives one code.
module ps2_kbd_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   input  logic       rx_scan_read,
   output logic       rx_scan_ready,
   output logic [7:0] rx_scan_code,
   output logic       rx_released,
   output logic       rx_extended,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t        r_state;
   logic          r_clk_s1, r_clk_s2;
   logic          r_dat_s1, r_dat_s2;
   logic [7:0]    r_flt_cnt;
   logic          r_flt_clk;
   logic [TW-1:0] r_to_cnt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_cnt;
   logic          r_parity;
   logic          r_ext_pend;
   logic          r_brk_pend;

   logic          w_flt_hit;
   logic          w_strobe;
   logic          w_timeout;
   logic          w_frame_ok;

   // the filtered clock toggles on the cycle the counter would reach FILTER_LEN
   assign w_flt_hit  = (r_clk_s2 != r_flt_clk)
                     && (r_flt_cnt == 8'(FILTER_LEN - 1));
   assign w_strobe   = w_flt_hit & r_flt_clk;
   assign w_timeout  = (r_state != S_IDLE) && !w_strobe
                     && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_frame_ok = (^r_shift ^ r_parity) & r_dat_s2;

   // two-flop synchronisers on both pins, idling high
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_i;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // glitch filter: the clock must disagree for FILTER_LEN cycles to flip
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_flt_cnt <= '0;
         r_flt_clk <= 1'b1;
      end else if (r_clk_s2 == r_flt_clk) begin
         r_flt_cnt <= '0;
      end else if (w_flt_hit) begin
         r_flt_cnt <= '0;
         r_flt_clk <= ~r_flt_clk;
      end else begin
         r_flt_cnt <= r_flt_cnt + 8'd1;
      end
   end

   // inter-edge watchdog, only running while a frame is in progress
   always_ff @(posedge clk_i) begin
      if (rst || r_state == S_IDLE || w_strobe || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   // frame FSM, prefix folding and consumer handshake
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_parity      <= 1'b0;
         r_ext_pend    <= 1'b0;
         r_brk_pend    <= 1'b0;
         rx_scan_ready <= 1'b0;
         rx_scan_code  <= '0;
         rx_released   <= 1'b0;
         rx_extended   <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
         if (rx_scan_ready && rx_scan_read) begin
            rx_scan_ready <= 1'b0;
         end
         if (w_timeout) begin
            r_state      <= S_IDLE;
            rx_frame_err <= 1'b1;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
         end else if (w_strobe) begin
            unique case (r_state)
               S_IDLE: begin
                  if (!r_dat_s2) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_PAR;
                  end
               end
               S_PAR: begin
                  r_parity <= r_dat_s2;
                  r_state  <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  if (!w_frame_ok) begin
                     rx_frame_err <= 1'b1;
                     r_ext_pend   <= 1'b0;
                     r_brk_pend   <= 1'b0;
                  end else if (r_shift == 8'hE0) begin
                     r_ext_pend <= 1'b1;
                  end else if (r_shift == 8'hF0) begin
                     r_brk_pend <= 1'b1;
                  end else begin
                     r_ext_pend <= 1'b0;
                     r_brk_pend <= 1'b0;
                     if (!rx_scan_ready || rx_scan_read) begin
                        rx_scan_code  <= r_shift;
                        rx_released   <= r_brk_pend;
                        rx_extended   <= r_ext_pend;
                        rx_scan_ready <= 1'b1;
                     end else begin
                        rx_overrun <= 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed and randomised frames against a byte-level model of the
// PS/2 receiver: prefix folding, errors, timeout, glitches, overrun, reset.
module tb_ps2_kbd_rx;

   logic       clk_i = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       tie = 1'b1;
   logic       rd = 1'b0;
   logic       rx_scan_read;
   logic       rx_scan_ready;
   logic [7:0] rx_scan_code;
   logic       rx_released;
   logic       rx_extended;
   logic       rx_frame_err;
   logic       rx_overrun;

   assign rx_scan_read = tie ? rx_scan_ready : rd;

   ps2_kbd_rx #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(2000)
   ) dut (
      .clk_i        (clk_i),
      .rst          (rst),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_dat),
      .rx_scan_read (rx_scan_read),
      .rx_scan_ready(rx_scan_ready),
      .rx_scan_code (rx_scan_code),
      .rx_released  (rx_released),
      .rx_extended  (rx_extended),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // observed event counters
   int   n_rise = 0;
   int   n_err = 0;
   int   n_ovr = 0;
   int   n_rdy_cyc = 0;
   logic r_prev = 1'b0;

   always @(negedge clk_i) begin
      if (rx_scan_ready && !r_prev) n_rise++;
      if (tie && rx_scan_ready) n_rdy_cyc++;
      if (rx_frame_err) n_err++;
      if (rx_overrun) n_ovr++;
      r_prev = rx_scan_ready;
   end

   // reference model state
   int         e_rise = 0;
   int         e_err = 0;
   int         e_ovr = 0;
   int         e_cyc = 0;
   logic [7:0] e_code = 8'h00;
   logic       e_rel = 1'b0;
   logic       e_ext = 1'b0;
   logic       m_ext = 1'b0;
   logic       m_brk = 1'b0;
   logic       m_rdy = 1'b0;
   int         last_lat;
   int         last_terr;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b,
                                           input logic bad);
      return {1'b1, ~(^b) ^ bad, b, 1'b0};
   endfunction

   // model: how one received byte (or a broken frame) changes the outputs
   task automatic model_byte(input logic [7:0] b, input logic ok);
      if (!ok) begin
         e_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (tie || !m_rdy) begin
            e_rise++;
            if (tie) e_cyc++;
            e_code = b;
            e_rel  = m_brk;
            e_ext  = m_ext;
            m_rdy  = !tie;
         end else begin
            e_ovr++;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rise"}, n_rise, e_rise);
      chk({tag, ".err"}, n_err, e_err);
      chk({tag, ".ovr"}, n_ovr, e_ovr);
      chk({tag, ".code"}, int'(rx_scan_code), int'(e_code));
      chk({tag, ".rel"}, int'(rx_released), int'(e_rel));
      chk({tag, ".ext"}, int'(rx_extended), int'(e_ext));
      if (tie) chk({tag, ".rdycyc"}, n_rdy_cyc, e_cyc);
   endtask

   // drive n bits of a frame; after the last falling edge watch for
   // ready / error for tail cycles (clock returns high after 200)
   task automatic send(input logic [10:0] f, input int n,
                       input int glitch, input int tail);
      int r0;
      int e0;
      r0 = n_rise;
      e0 = n_err;
      last_lat  = -1;
      last_terr = -1;
      for (int k = 0; k < n; k++) begin
         ps2_dat = f[k];
         if (k == glitch) begin
            repeat (100) @(negedge clk_i);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk_i);
            ps2_clk = 1'b1;
            repeat (97) @(negedge clk_i);
         end else begin
            repeat (200) @(negedge clk_i);
         end
         ps2_clk = 1'b0;
         if (k < n - 1) begin
            repeat (200) @(negedge clk_i);
            ps2_clk = 1'b1;
         end else begin
            for (int i = 1; i <= tail; i++) begin
               @(negedge clk_i);
               #1;
               if (i == 200) ps2_clk = 1'b1;
               if (last_lat < 0 && n_rise != r0) last_lat = i;
               if (last_terr < 0 && n_err != e0) last_terr = i;
            end
         end
      end
      ps2_dat = 1'b1;
   endtask

   task automatic sb(input string tag, input logic [7:0] b,
                     input logic bad, input int glitch);
      send(mkframe(b, bad), 11, glitch, 400);
      model_byte(b, !bad);
      check_all(tag);
   endtask

   initial begin
      logic [7:0] b;
      logic       bad;
      int         r0;

      repeat (5) @(negedge clk_i);
      chk("rst.ready", int'(rx_scan_ready), 0);
      chk("rst.code", int'(rx_scan_code), 0);
      chk("rst.flags", int'({rx_released, rx_extended}), 0);
      chk("rst.pulses", int'({rx_frame_err, rx_overrun}), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk_i);

      sb("k1C", 8'h1C, 1'b0, -1);
      chk("k1C.lat", int'(last_lat > 0 && last_lat <= 12), 1);

      sb("F0", 8'hF0, 1'b0, -1);
      sb("F0_1C", 8'h1C, 1'b0, -1);
      sb("E0", 8'hE0, 1'b0, -1);
      sb("E0F0", 8'hF0, 1'b0, -1);
      sb("E0F0_75", 8'h75, 1'b0, -1);
      sb("back1C", 8'h1C, 1'b0, -1);

      sb("badpar", 8'h1C, 1'b1, -1);
      sb("k29", 8'h29, 1'b0, -1);

      send(mkframe(8'h5A, 1'b0), 6, -1, 2100);
      model_byte(8'h00, 1'b0);
      check_all("tmo");
      chk("tmo.when", int'(last_terr >= 2000 && last_terr <= 2014), 1);
      sb("tmo_5A", 8'h5A, 1'b0, -1);
      sb("tmo_E0", 8'hE0, 1'b0, -1);
      send(mkframe(8'h33, 1'b0), 4, -1, 2100);
      model_byte(8'h00, 1'b0);
      check_all("tmo2");
      sb("tmo2_5A", 8'h5A, 1'b0, -1);

      ps2_clk = 1'b0;
      repeat (3) @(negedge clk_i);
      ps2_clk = 1'b1;
      repeat (50) @(negedge clk_i);
      check_all("glitch_idle");
      sb("glitch_mid", 8'h1C, 1'b0, 4);

      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            default: begin
               b = 8'($urandom_range(0, 255));
               if (b == 8'hE0 || b == 8'hF0) b = 8'h12;
            end
         endcase
         bad = ($urandom_range(0, 7) == 0);
         r0  = e_rise;
         sb("rnd", b, bad, -1);
         if (e_rise != r0) chk("rnd.lat", int'(last_lat > 0 && last_lat <= 12), 1);
      end

      tie = 1'b0;
      rd  = 1'b0;
      sb("ovr_1C", 8'h1C, 1'b0, -1);
      sb("ovr_32", 8'h32, 1'b0, -1);
      chk("ovr.ready_held", int'(rx_scan_ready), 1);
      @(negedge clk_i);
      rd = 1'b1;
      @(negedge clk_i);
      rd = 1'b0;
      m_rdy = 1'b0;
      chk("ovr.ready_clr", int'(rx_scan_ready), 0);

      send(mkframe(8'h3A, 1'b0), 4, -1, 10);
      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("mrst.ready", int'(rx_scan_ready), 0);
      chk("mrst.code", int'(rx_scan_code), 0);
      chk("mrst.flags", int'({rx_released, rx_extended}), 0);
      chk("mrst.pulses", int'({rx_frame_err, rx_overrun}), 0);
      rst = 1'b0;
      e_code = 8'h00;
      e_rel  = 1'b0;
      e_ext  = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_rdy  = 1'b0;
      repeat (2100) @(negedge clk_i);
      check_all("mrst.quiet");
      tie = 1'b1;
      sb("mrst_3A", 8'h3A, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
